// File: rtl/pin_out_serializer.sv
// Parallel-to-serial feeder for an SDR clock-enabled pad output register.
// Optional even-parity bit is appended when PIN_OUT_SER_PARITY_EN is defined.
//
// state   | meaning
// S_IDLE  | no word in flight, ser_d parked at IDLE_LEVEL, ready for a word
// S_SHIFT | word in flight, each bit held for period_q+1 cycles
module pin_out_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   DIV_W      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIV_W-1:0] div,
    output logic             ser_d,
    output logic             ser_sp,
    output logic             busy,
    output logic             last_bit
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PIN_OUT_SER_PARITY_EN
    localparam int LAST_IDX = WIDTH;
`else
    localparam int LAST_IDX = WIDTH - 1;
`endif
    localparam logic [CNT_W-1:0] FINAL    = CNT_W'(LAST_IDX);
    localparam logic [CNT_W-1:0] DATA_END = CNT_W'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]   period_q, period_d;
    logic               ser_d_q, ser_d_d;
    logic               ser_sp_q, ser_sp_d;
    logic               accept;
    logic               next_bit;
`ifdef PIN_OUT_SER_PARITY_EN
    logic               parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            period_q  <= '0;
            ser_d_q   <= IDLE_LEVEL;
            ser_sp_q  <= 1'b0;
`ifdef PIN_OUT_SER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            period_q  <= period_d;
            ser_d_q   <= ser_d_d;
            ser_sp_q  <= ser_sp_d;
`ifdef PIN_OUT_SER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign accept = in_valid & in_ready;

    // Next bit comes from the shifter; after the last data bit it is the parity bit.
    always_comb begin
        next_bit = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
`ifdef PIN_OUT_SER_PARITY_EN
        if (bit_cnt_q == DATA_END) next_bit = parity_q;
`endif
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        period_d  = period_q;
        ser_d_d   = ser_d_q;
        ser_sp_d  = 1'b0;
`ifdef PIN_OUT_SER_PARITY_EN
        parity_d  = parity_q;
`endif
        if (accept) begin
            state_d   = S_SHIFT;
            shreg_d   = in_data;
            period_d  = div;
            div_cnt_d = div;
            bit_cnt_d = '0;
            ser_d_d   = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
            ser_sp_d  = 1'b1;
`ifdef PIN_OUT_SER_PARITY_EN
            parity_d  = ^in_data;
`endif
        end else if (state_q == S_SHIFT) begin
            if (div_cnt_q != '0) begin
                div_cnt_d = div_cnt_q - DIV_W'(1);
            end else if (bit_cnt_q != FINAL) begin
                shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                ser_d_d   = next_bit;
                ser_sp_d  = 1'b1;
                div_cnt_d = period_q;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end else begin
                // Word done with nothing queued: one pulse parks the pad at idle.
                state_d  = S_IDLE;
                ser_d_d  = IDLE_LEVEL;
                ser_sp_d = 1'b1;
            end
        end
    end

    always_comb begin
        busy     = (state_q == S_SHIFT);
        last_bit = busy && (bit_cnt_q == FINAL);
        in_ready = (state_q == S_IDLE) || (last_bit && (div_cnt_q == '0));
        ser_d    = ser_d_q;
        ser_sp   = ser_sp_q;
    end

    // DATA_END is only consulted when parity is built in.
    logic unused_ok;
    assign unused_ok = ^DATA_END;

endmodule

// File: tb/tb_pin_out_serializer.sv
// Directed bench for pin_out_serializer: an MSB-first and an LSB-first instance
// share clock, reset, data and divider; each has its own in_valid.
module tb_pin_out_serializer;

`ifdef PIN_OUT_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] in_data;
    logic [7:0] div;
    logic       in_valid_m, in_valid_l;
    logic       in_ready_m, ser_d_m, ser_sp_m, busy_m, last_m;
    logic       in_ready_l, ser_d_l, ser_sp_l, busy_l, last_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pin_out_serializer #(.WIDTH(8), .DIV_W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_m (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid_m),
        .in_ready(in_ready_m), .div(div), .ser_d(ser_d_m), .ser_sp(ser_sp_m),
        .busy(busy_m), .last_bit(last_m)
    );

    pin_out_serializer #(.WIDTH(8), .DIV_W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid_l),
        .in_ready(in_ready_l), .div(div), .ser_d(ser_d_l), .ser_sp(ser_sp_l),
        .busy(busy_l), .last_bit(last_l)
    );

    typedef struct {
        logic       vin;
        logic [7:0] data;
        logic [7:0] dv;
        logic       d, sp, bsy, rdy, lst;
    } vec_t;

    vec_t tv[12];
    int   nv;

    // {ser_d, ser_sp, busy, in_ready, last_bit} of the selected instance
    function automatic logic [4:0] outs(input bit msb);
        if (msb) return {ser_d_m, ser_sp_m, busy_m, in_ready_m, last_m};
        return {ser_d_l, ser_sp_l, busy_l, in_ready_l, last_l};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk5(input string tag, input logic [4:0] o,
                        input logic d, input logic sp, input logic bsy,
                        input logic rdy, input logic lst);
        chk({tag, " ser_d"},    32'(o[4]), 32'(d));
        chk({tag, " ser_sp"},   32'(o[3]), 32'(sp));
        chk({tag, " busy"},     32'(o[2]), 32'(bsy));
        chk({tag, " in_ready"}, 32'(o[1]), 32'(rdy));
        chk({tag, " last_bit"}, 32'(o[0]), 32'(lst));
    endtask

    // Send one word from idle and check every cycle through the trailing idle pulse.
    task automatic run_word(input logic [7:0] data, input logic [7:0] dv, input bit msb);
        int   per, nb, pulses, b;
        logic eb;
        per    = int'(dv) + 1;
        nb     = 8 + PAR;
        pulses = 0;
        in_data = data;
        div     = dv;
        if (msb) in_valid_m = 1'b1; else in_valid_l = 1'b1;
        chk($sformatf("rw %0h ready at accept", data), 32'(outs(msb)), 32'(5'b10010));
        step();
        in_valid_m = 1'b0;
        in_valid_l = 1'b0;
        in_data    = ~data;
        div        = 8'hFF;
        for (int k = 1; k <= nb * per; k++) begin
            b = (k - 1) / per;
            if (b < 8) eb = msb ? data[7-b] : data[b];
            else       eb = ^data;
            chk5($sformatf("rw %0h k=%0d", data, k), outs(msb), eb,
                 ((k - 1) % per) == 0, 1'b1,
                 (b == nb - 1) && (k % per == 0), b == nb - 1);
            if (outs(msb) >> 3 & 5'b1) pulses++;
            step();
        end
        chk($sformatf("rw %0h pulses", data), 32'(pulses), 32'(nb));
        chk5($sformatf("rw %0h idle pulse", data), outs(msb), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk5($sformatf("rw %0h quiet", data), outs(msb), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int   pulses, nb, b;
        logic eb;
        logic [7:0] w;

        resetn     = 1'b0;
        in_valid_m = 1'b0;
        in_valid_l = 1'b0;
        in_data    = 8'h00;
        div        = 8'h00;

        // 0xA5 at div=0 on the MSB-first instance, one row per cycle
        tv[0]  = '{1'b1, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[1]  = '{1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[6]  = '{1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef PIN_OUT_SER_PARITY_EN
        tv[8]  = '{1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tv[10] = '{1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[11] = '{1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        nv = 12;
`else
        tv[8]  = '{1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tv[9]  = '{1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[10] = '{1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[11] = '{1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        nv = 11;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step();

        for (int i = 0; i < 20; i++) begin
            chk5($sformatf("idle m c=%0d", i), outs(1'b1), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            chk5($sformatf("idle l c=%0d", i), outs(1'b0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            step();
        end

        for (int i = 0; i < nv; i++) begin
            in_valid_m = tv[i].vin;
            in_data    = tv[i].data;
            div        = tv[i].dv;
            chk5($sformatf("a5 row=%0d", i), outs(1'b1),
                 tv[i].d, tv[i].sp, tv[i].bsy, tv[i].rdy, tv[i].lst);
            step();
        end

        run_word(8'h01, 8'd3, 1'b0);

        // Back-to-back 0xFF then 0x00 at div=1 with in_valid held
        nb = 8 + PAR;
        pulses = 0;
        in_data    = 8'hFF;
        div        = 8'd1;
        in_valid_m = 1'b1;
        chk("b2b first accept ready", 32'(in_ready_m), 32'd1);
        step();
        in_data = 8'h00;
        for (int k = 1; k <= 4 * nb; k++) begin
            if (k == 2 * nb + 1) in_valid_m = 1'b0;
            w  = (k <= 2 * nb) ? 8'hFF : 8'h00;
            b  = ((k - 1) % (2 * nb)) / 2;
            eb = (b < 8) ? w[7-b] : ^w;
            chk5($sformatf("b2b k=%0d", k), outs(1'b1), eb, (k % 2) == 1, 1'b1,
                 (k % (2 * nb)) == 0, b == nb - 1);
            if (ser_sp_m) pulses++;
            step();
        end
        chk("b2b pulses", 32'(pulses), 32'(2 * nb));
        chk5("b2b idle pulse", outs(1'b1), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();

        // Reset on the first cycle of bit 3 of 0x5A at div=2
        in_data    = 8'h5A;
        div        = 8'd2;
        in_valid_m = 1'b1;
        step();
        in_valid_m = 1'b0;
        repeat (9) step();
        chk5("rst before", outs(1'b1), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        chk5("rst during", outs(1'b1), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        chk5("rst after release", outs(1'b1), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_word(8'h5A, 8'd0, 1'b1);

        run_word(8'h07, 8'd0, 1'b1);
        run_word(8'h3C, 8'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
